// File: rtl/seg_anim_pkg.sv
// Shared definitions for the multiplexed 7-segment animator: mode encodings,
// segment bit positions, sequence lengths and the per-mode pattern lookup.
package seg_anim_pkg;

    typedef enum logic [1:0] {
        MODE_SPIN_CW  = 2'd0,
        MODE_SPIN_CCW = 2'd1,
        MODE_FILL     = 2'd2,
        MODE_SNAKE    = 2'd3
    } mode_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;

    localparam int FILL_LEN = 7;
    localparam int SPIN_LEN = 6;

    // Outer-ring pattern for a given mode and animation position.
    // FILL position 6 is the blank frame before the sequence restarts.
    function automatic logic [5:0] seg_pattern(input mode_e mode, input logic [2:0] pos);
        logic [5:0] pat;
        logic [6:0] fill;
        pat  = '0;
        fill = '0;
        case (mode)
            MODE_SPIN_CCW: begin
                if (pos == 3'd0)
                    pat = 6'b000001;
                else
                    pat = 6'b000001 << (3'd6 - pos);
            end
            MODE_FILL: begin
                if (pos < 3'd6) begin
                    fill = (7'd1 << (pos + 3'd1)) - 7'd1;
                    pat  = fill[5:0];
                end else begin
                    pat = 6'b000000;
                end
            end
            default: pat = 6'b000001 << pos;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock-enable prescaler: pulses io_tick combinationally on the last count of
// each CYCLES-long period; the count only moves while io_en is high.
module tick_divider #(
    parameter int CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic io_en,
    output logic io_tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] count;

    assign io_tick = io_en && (count == LAST);

    // Holding the count while disabled preserves the remaining time to the next tick.
    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (io_en)
            count <= io_tick ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/seg_anim_mux.sv
// Multiplexed N-digit outer-ring animator: an animation step prescaler drives
// the pattern position, a free-running scan prescaler rotates the digit select.
module seg_anim_mux
    import seg_anim_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int STEP_CYCLES = 12000000,
    parameter int SCAN_CYCLES = 12000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enable,
    input  logic [1:0]        io_mode,
    output logic [5:0]        io_segAtoF,
    output logic [DIGITS-1:0] io_digitSel,
    output logic              io_wrap
);

    localparam int HW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_RESET = DIGITS'(1);
    localparam logic [5:0] SEG_RESET = 6'(1 << SEG_A);

    logic              step_tick;
    logic              scan_tick;
    mode_e             cur_mode;
    mode_e             mode_n;
    mode_e             mode_in;
    logic [2:0]        pos;
    logic [2:0]        pos_n;
    logic [2:0]        last_pos;
    logic [HW-1:0]     h;
    logic [HW-1:0]     h_n;
    logic [DIGITS-1:0] sel_n;
    logic [5:0]        pat;
    logic [5:0]        seg_n;
    logic              wrap_n;

    tick_divider #(.CYCLES(STEP_CYCLES)) u_step_div (
        .clock  (clock),
        .reset  (reset),
        .io_en  (io_enable),
        .io_tick(step_tick)
    );

    tick_divider #(.CYCLES(SCAN_CYCLES)) u_scan_div (
        .clock  (clock),
        .reset  (reset),
        .io_en  (1'b1),
        .io_tick(scan_tick)
    );

    assign mode_in = mode_e'(io_mode);

    // Everything is computed from the post-edge state so segments and digit
    // select stay aligned even when both ticks land on the same edge.
    always_comb begin
        mode_n   = cur_mode;
        pos_n    = pos;
        h_n      = h;
        wrap_n   = 1'b0;
        sel_n    = io_digitSel;
        last_pos = (cur_mode == MODE_FILL) ? 3'(FILL_LEN - 1) : 3'(SPIN_LEN - 1);

        if (step_tick) begin
            if (mode_in != cur_mode) begin
                mode_n = mode_in;
                pos_n  = '0;
                h_n    = '0;
            end else if (pos == last_pos) begin
                pos_n  = '0;
                wrap_n = 1'b1;
                if (cur_mode == MODE_SNAKE)
                    h_n = (h == H_LAST) ? '0 : h + 1'b1;
            end else begin
                pos_n = pos + 3'd1;
            end
        end

        // Shift-or form also covers DIGITS = 1, where the select stays constant.
        if (scan_tick)
            sel_n = (io_digitSel << 1) | (io_digitSel >> (DIGITS - 1));

        pat = seg_pattern(mode_n, pos_n);
        if (mode_n == MODE_SNAKE && !sel_n[h_n])
            seg_n = '0;
        else
            seg_n = pat;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_mode    <= MODE_SPIN_CW;
            pos         <= '0;
            h           <= '0;
            io_segAtoF  <= SEG_RESET;
            io_digitSel <= SEL_RESET;
            io_wrap     <= 1'b0;
        end else begin
            cur_mode    <= mode_n;
            pos         <= pos_n;
            h           <= h_n;
            io_segAtoF  <= seg_n;
            io_digitSel <= sel_n;
            io_wrap     <= wrap_n;
        end
    end

endmodule

// File: tb/tb_seg_anim_mux.sv
// Randomised and directed bench for seg_anim_mux against a table-driven
// behavioural model of the animation and scan timing.
module tb_seg_anim_mux;

    localparam int DIGITS      = 4;
    localparam int STEP_CYCLES = 4;
    localparam int SCAN_CYCLES = 2;

    logic              clock;
    logic              reset;
    logic              io_enable;
    logic [1:0]        io_mode;
    logic [5:0]        io_segAtoF;
    logic [DIGITS-1:0] io_digitSel;
    logic              io_wrap;

    int num_checks;
    int num_errors;

    // Behavioural model state: plain integer counters and sequence tables.
    int m_step;
    int m_scan;
    int m_mode;
    int m_pos;
    int m_h;
    int m_dig;
    logic [5:0]        exp_seg;
    logic [DIGITS-1:0] exp_sel;
    logic              exp_wrap;

    logic [5:0] cw_tab   [0:5] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    logic [5:0] ccw_tab  [0:5] = '{6'b000001, 6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000010};
    logic [5:0] fill_tab [0:6] = '{6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111, 6'b000000};

    seg_anim_mux #(
        .DIGITS     (DIGITS),
        .STEP_CYCLES(STEP_CYCLES),
        .SCAN_CYCLES(SCAN_CYCLES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_enable  (io_enable),
        .io_mode    (io_mode),
        .io_segAtoF (io_segAtoF),
        .io_digitSel(io_digitSel),
        .io_wrap    (io_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelEdge(input logic rst, input logic en, input int mode);
        bit step_tick;
        bit scan_tick;
        int len;
        exp_wrap = 1'b0;
        if (rst) begin
            m_step = 0; m_scan = 0; m_mode = 0; m_pos = 0; m_h = 0; m_dig = 0;
        end else begin
            step_tick = en && (m_step == STEP_CYCLES - 1);
            if (en) m_step = step_tick ? 0 : m_step + 1;
            scan_tick = (m_scan == SCAN_CYCLES - 1);
            m_scan = scan_tick ? 0 : m_scan + 1;
            if (step_tick) begin
                if (mode != m_mode) begin
                    m_mode = mode; m_pos = 0; m_h = 0;
                end else begin
                    len = (m_mode == 2) ? 7 : 6;
                    m_pos = (m_pos + 1) % len;
                    if (m_pos == 0) begin
                        exp_wrap = 1'b1;
                        if (m_mode == 3) m_h = (m_h + 1) % DIGITS;
                    end
                end
            end
            if (scan_tick) m_dig = (m_dig + 1) % DIGITS;
        end
        case (m_mode)
            1:       exp_seg = ccw_tab[m_pos];
            2:       exp_seg = fill_tab[m_pos];
            default: exp_seg = cw_tab[m_pos];
        endcase
        if (m_mode == 3 && m_dig != m_h) exp_seg = 6'b000000;
        exp_sel = DIGITS'(1) << m_dig;
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] mode);
        reset     = rst;
        io_enable = en;
        io_mode   = mode;
        @(posedge clock);
        modelEdge(rst, en, int'(mode));
        #1;
        checkOutput("seg", 32'(io_segAtoF), 32'(exp_seg));
        checkOutput("sel", 32'(io_digitSel), 32'(exp_sel));
        checkOutput("wrap", 32'(io_wrap), 32'(exp_wrap));
    endtask

    task automatic runCycles(input int n, input logic en, input logic [1:0] mode);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, en, mode);
    endtask

    initial begin
        logic [1:0] r_mode;
        logic       r_rst;
        logic       r_en;
        num_checks = 0;
        num_errors = 0;
        reset = 1'b1; io_enable = 1'b0; io_mode = 2'd0;

        // Reset state against literal values.
        applyStimulus(1'b1, 1'b0, 2'd0);
        checkOutput("reset_seg", 32'(io_segAtoF), 32'h01);
        checkOutput("reset_sel", 32'(io_digitSel), 32'h1);
        checkOutput("reset_wrap", 32'(io_wrap), 32'h0);

        // Spin CW: six ticks at 4 clocks each bring the wrap on edge 24.
        runCycles(24, 1'b1, 2'd0);
        checkOutput("cw_wrap_seg", 32'(io_segAtoF), 32'h01);
        checkOutput("cw_wrap_pulse", 32'(io_wrap), 32'h1);
        checkOutput("cw_wrap_sel", 32'(io_digitSel), 32'h1);
        runCycles(4, 1'b1, 2'd0);

        $display("[TB] spin CCW from reset");
        applyStimulus(1'b1, 1'b0, 2'd1);
        runCycles(30, 1'b1, 2'd1);

        $display("[TB] fill from reset");
        applyStimulus(1'b1, 1'b0, 2'd2);
        runCycles(64, 1'b1, 2'd2);

        $display("[TB] snake from reset, four revolutions");
        applyStimulus(1'b1, 1'b0, 2'd3);
        runCycles(4 + 4 * 6 * 4 + 8, 1'b1, 2'd3);

        $display("[TB] enable low at 000100");
        applyStimulus(1'b1, 1'b0, 2'd0);
        runCycles(9, 1'b1, 2'd0);
        checkOutput("hold_start", 32'(io_segAtoF), 32'h04);
        runCycles(20, 1'b0, 2'd0);
        checkOutput("hold_seg", 32'(io_segAtoF), 32'h04);
        runCycles(10, 1'b1, 2'd0);

        $display("[TB] mode change at 001000");
        applyStimulus(1'b1, 1'b0, 2'd0);
        runCycles(12, 1'b1, 2'd0);
        checkOutput("chg_before", 32'(io_segAtoF), 32'h08);
        runCycles(4, 1'b1, 2'd2);
        checkOutput("chg_seg", 32'(io_segAtoF), 32'h01);
        checkOutput("chg_wrap", 32'(io_wrap), 32'h0);

        $display("[TB] reset mid-operation at 010000");
        applyStimulus(1'b1, 1'b0, 2'd0);
        runCycles(17, 1'b1, 2'd0);
        checkOutput("mid_before", 32'(io_segAtoF), 32'h10);
        applyStimulus(1'b1, 1'b1, 2'd0);
        checkOutput("mid_seg", 32'(io_segAtoF), 32'h01);
        checkOutput("mid_sel", 32'(io_digitSel), 32'h1);

        $display("[TB] randomised run");
        r_mode = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) r_mode = 2'($urandom_range(0, 3));
            r_en = ($urandom_range(0, 7) != 0);
            applyStimulus(r_rst, r_en, r_mode);
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/seg_anim_mux.md
Name: seg_anim_mux

Overview:
- Parametrised successor to the single-digit segment spinner.
- Drives N multiplexed 7-segment digits on the outer ring (segments a–f) with selectable animation modes.
- Two independent internal prescalers: an animation step tick and a digit-scan tick.
- Sits between the board clock and the LED display pins; segment and digit outputs are registered and always aligned.

Parameters:
- DIGITS, 4, number of multiplexed digits (>=1)
- STEP_CYCLES, 12000000, clocks per animation step (>=1; 1 = step every clock)
- SCAN_CYCLES, 12000, clocks per digit-scan slot (>=1)

Ports:
- clock  in  1  system clock, single domain
- reset  in  1  synchronous, active-high reset
- io_enable  in  1  1 = animation advances; 0 = animation frozen (scan continues)
- io_mode  in  2  0 SPIN_CW, 1 SPIN_CCW, 2 FILL, 3 SNAKE
- io_segAtoF  out  6  active-high segments, bit0=a … bit5=f, for the currently selected digit
- io_digitSel  out  DIGITS  one-hot active-high digit select
- io_wrap  out  1  one-clock pulse when the animation position wraps to 0 by normal advance

Behaviour:
- Reset values (synchronous; takes effect on the next edge, including mid-operation):
  - io_segAtoF = 6'b000001, io_digitSel = 1 (digit 0), io_wrap = 0
  - pos = 0, hot digit h = 0, cur_mode = 0, both prescaler counters = 0
- Step prescaler:
  - Counter width $clog2(STEP_CYCLES) (min 1); counts only while io_enable = 1.
  - Tick when count == STEP_CYCLES-1; count returns to 0 on that edge.
  - When io_enable = 0, the count holds and the remaining count is preserved.
- Scan prescaler:
  - Free-running, independent of io_enable.
  - On its tick, io_digitSel rotates left (MSB wraps to bit0).
- Mode sampling:
  - io_mode is sampled only on a step tick.
  - If the sampled mode ≠ cur_mode: cur_mode takes the new value, pos = 0, h = 0, no io_wrap.
  - Otherwise the position advances as below.
- Position advance on a step tick:
  - SPIN_CW: pos 0..5 → 0; pattern = 1<<pos, giving a,b,c,d,e,f.
  - SPIN_CCW: pos 0..5 → 0; pattern = 1<<((6-pos)%6), giving a,f,e,d,c,b.
  - FILL: pos 0..6 → 0; pattern = (1<<(pos+1))-1 for pos<6 (000001 … 111111); pos 6 = 000000.
  - SNAKE: pos as SPIN_CW; on the pos 5→0 wrap, h increments, wrapping DIGITS-1 → 0.
- io_wrap: high for exactly one clock, on the edge where pos goes from its last value to 0 by normal advance.
- Output latency:
  - Outputs register the state that results from the current edge, so an advance or scan change is visible the cycle after the tick.
  - io_segAtoF always corresponds to the digit shown on io_digitSel in the same cycle.
- Per-digit pattern:
  - Modes 0–2: every digit shows the same pattern.
  - SNAKE: digit h shows the pattern; all other digits show 000000.
- Simultaneous events:
  - Step tick and scan tick on the same edge: both apply, and seg is computed for the new digit using the new pos/h.
  - Reset has priority over everything.
- DIGITS = 1: io_digitSel is constant 1 and SNAKE behaves as SPIN_CW.

Decomposition:
- Shared package seg_anim_pkg:
  - mode encodings MODE_SPIN_CW/CCW/FILL/SNAKE
  - segment bit indices SEG_A..SEG_F
  - FILL_LEN = 7 and SPIN_LEN = 6
- One sub-module: tick_divider (parameter CYCLES; ports clock, reset, io_en, io_tick), instantiated twice.
  - Step instance: io_en = io_enable.
  - Scan instance: io_en = 1.
- Pattern generation is combinational logic inside seg_anim_mux.

Test Plan:
Bench parameters: DIGITS=4, STEP_CYCLES=4, SCAN_CYCLES=2.
- Reset then mode 0, enable 1:
  - io_segAtoF steps 000001→000010→000100→001000→010000→100000→000001, one change every 4 clocks.
  - io_wrap pulses once, coincident with the return to 000001.
  - io_digitSel cycles 0001→0010→0100→1000 every 2 clocks.
- Mode 1 from reset: the first tick samples the mode change and yields 000001 with no wrap; after that 100000, 010000, 001000, 000100, 000010, 000001 with an io_wrap pulse.
- Mode 2: sequence 000001, 000011, 000111, 001111, 011111, 111111, 000000, 000001; wrap period 28 clocks.
- Mode 3: seg is nonzero only while io_digitSel=0001 for 6 steps; after the wrap it is nonzero only on 0010; after 4 revolutions it is back on 0001.
- Enable low at pattern 000100 for 20 clocks:
  - io_segAtoF holds while io_digitSel keeps rotating.
  - After re-enable, the next change occurs after the preserved remaining count.
- Mode 0→2 change at 001000 gives 000001 at the next tick with io_wrap = 0.
- Reset asserted at 010000 gives 000001 and 0001 on the next edge.
